// File: rtl/data_mem_pkg.sv
// data_mem_pkg: access-size codes, clear-FSM encoding and load extraction shared by the data memory.
// Contents: SZ_* size codes, ST_* state constants, ld_extract() byte/half/word load formatter.
package data_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    // Picks the addressed byte/half out of a stored word and right-justifies it with sign or zero fill.
    function automatic logic [31:0] ld_extract(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [1:0]  size,
        input logic        sext
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*lane +: 8];
        h = word[16*lane[1] +: 16];
        return size == SZ_BYTE ? {{24{sext & b[7]}}, b} :
               size == SZ_HALF ? {{16{sext & h[15]}}, h} :
               size == SZ_WORD ? word : 32'h0;
    endfunction

endpackage

// File: rtl/data_mem_sized_align.sv
// data_mem_sized_align: store lane steering for byte/half/word accesses.
// Ports: size_i (access size), addr_i (low address bits), wdata_i (right-justified store data);
//        be_o (byte enables), wword_o (data replicated onto its lanes), aligned_o (address legal for size).
module mem_lane_align
    import data_mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic        aligned_o
);

    always_comb begin
        be_o = size_i == SZ_BYTE ? 4'b0001 << addr_i :
               size_i == SZ_HALF ? (addr_i[1] ? 4'b1100 : 4'b0011) :
               size_i == SZ_WORD ? 4'b1111 : 4'b0000;
        // Replicating the small datum onto every lane lets the byte enables alone pick the target lanes.
        wword_o = size_i == SZ_BYTE ? {4{wdata_i[7:0]}} :
                  size_i == SZ_HALF ? {2{wdata_i[15:0]}} : wdata_i;
        aligned_o = size_i == SZ_BYTE ? 1'b1 :
                    size_i == SZ_HALF ? ~addr_i[0] :
                    size_i == SZ_WORD ? addr_i == 2'b00 : 1'b0;
    end

endmodule

// File: rtl/data_mem_sized.sv
// data_mem_sized: sized load/store data memory with range/alignment checks and a post-reset clear sequencer.
// Ports: clk, reset (sync, active-low); rd_i/wr_i requests, size_i, sext_i, addr_i (byte), wdata_i;
//        rdata_o (extended load data), busy_o (clear running), err_o (previous access rejected).
module data_mem_sized
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned READ_LAT  = 0,
    parameter int unsigned DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_i,
    input  logic              wr_i,
    input  logic [1:0]        size_i,
    input  logic              sext_i,
    input  logic [31:0]       addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [0:0]        state_q, state_d;
    logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
    logic              err_q, err_d;
    logic [32:0]       diff;
    logic [AW-1:0]     widx;
    logic [3:0]        be;
    logic [31:0]       wword;
    logic              aligned, in_range, busy, ok;
    logic [31:0]       rdata_c;

    mem_lane_align u_align (
        .size_i   (size_i),
        .addr_i   (addr_i[1:0]),
        .wdata_i  (wdata_i),
        .be_o     (be),
        .wword_o  (wword),
        .aligned_o(aligned)
    );

    // The extra top bit is the borrow, so addresses below BASE_ADDR land far above the limit.
    assign diff     = {1'b0, addr_i} - {1'b0, BASE_ADDR};
    assign in_range = diff < 33'(DEPTH) * 33'd4;
    assign widx     = diff[AW+1:2];
    assign busy     = state_q == ST_CLEAR;
    assign ok       = in_range & aligned & (size_i != SZ_RSVD) & ~busy;
    assign rdata_c  = rd_i && ok ? ld_extract(mem_q[widx], addr_i[1:0], size_i, sext_i) : 32'h0;
    assign busy_o   = busy;
    assign err_o    = err_q;

    always_comb begin
        state_d   = busy && clr_cnt_q == AW'(DEPTH - 1) ? ST_IDLE : state_q;
        clr_cnt_d = busy ? clr_cnt_q + AW'(1) : clr_cnt_q;
        err_d     = (rd_i | wr_i) & ~ok;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            err_q     <= err_d;
        end
    end

    // Array kept out of the reset branch so it can map onto RAM; the clear sequencer zeroes it instead.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (reset && wr_i && ok) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[widx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

    generate
        if (READ_LAT != 0) begin : g_reg
            logic [DATA_W-1:0] rdata_q;
            always_ff @(posedge clk) begin
                if (!reset) rdata_q <= '0;
                else        rdata_q <= rdata_c;
            end
            assign rdata_o = rdata_q;
        end else begin : g_comb
            assign rdata_o = rdata_c;
        end
    endgenerate

endmodule

// File: tb/tb_data_mem_sized.sv
// tb_data_mem_sized: directed checks of data_mem_sized with combinational (u0) and registered (u1) read ports.
module tb_data_mem_sized;
    import data_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rd = 1'b0, wr = 1'b0, sext = 1'b0;
    logic [1:0]  size = SZ_WORD;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic [31:0] rdata0, rdata1;
    logic        busy0, busy1, err0, err1;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    data_mem_sized #(.DEPTH(256), .BASE_ADDR(32'h0), .READ_LAT(0), .DATA_W(32)) u0 (
        .clk(clk), .reset(reset), .rd_i(rd), .wr_i(wr), .size_i(size), .sext_i(sext),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata0), .busy_o(busy0), .err_o(err0)
    );

    data_mem_sized #(.DEPTH(256), .BASE_ADDR(32'h0), .READ_LAT(1), .DATA_W(32)) u1 (
        .clk(clk), .reset(reset), .rd_i(rd), .wr_i(wr), .size_i(size), .sext_i(sext),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata1), .busy_o(busy1), .err_o(err1)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d);
        rd = r; wr = w; size = sz; sext = sx; addr = a; wdata = d;
    endtask

    task automatic idle();
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        drive(1'b0, 1'b1, sz, 1'b0, a, d);
        cyc();
        idle();
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while ((busy0 || busy1) && n < 1000) begin
            cyc();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b0;
        idle();
        repeat (3) cyc();
        vectors++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1 || err0 !== 1'b0 || rdata1 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b/%b err=%b rdata1=%h, need busy=1/1 err=0 rdata1=0",
                     busy0, busy1, err0, rdata1);
        end
        reset = 1'b1;
        count_busy(n);
        vectors++;
        if (n != 256) begin
            miscompares++;
            $display("FAIL clear_length: busy cycles=%0d, need 256", n);
        end
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'(i * 4), 32'h0);
            #1;
            vectors++;
            if (rdata0 !== 32'h0) begin
                miscompares++;
                $display("FAIL clear_word0 %0d: rdata=%h, need 0", i, rdata0);
            end
            cyc();
            vectors++;
            if (rdata1 !== 32'h0 || err0 !== 1'b0) begin
                miscompares++;
                $display("FAIL clear_word1 %0d: rdata=%h err=%b, need 0/0", i, rdata1, err0);
            end
        end
        idle();
        cyc();
    endtask

    task automatic test_byte_word();
        logic [31:0] la [5] = '{32'h10, 32'h13, 32'h13, 32'h12, 32'h10};
        logic [1:0]  ls [5] = '{SZ_WORD, SZ_BYTE, SZ_BYTE, SZ_BYTE, SZ_HALF};
        logic        lx [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] le [5] = '{32'hDE5ABEEF, 32'hFFFFFFDE, 32'h000000DE, 32'h0000005A, 32'hFFFFBEEF};
        store(SZ_WORD, 32'h10, 32'hDEADBEEF);
        vectors++;
        if (err0 !== 1'b0) begin
            miscompares++;
            $display("FAIL sw_err: err=%b, need 0", err0);
        end
        store(SZ_BYTE, 32'h12, 32'h0000005A);
        vectors++;
        if (err0 !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_err: err=%b, need 0", err0);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, ls[i], lx[i], la[i], 32'h0);
            #1;
            vectors++;
            if (rdata0 !== le[i]) begin
                miscompares++;
                $display("FAIL load0_%0d: rdata=%h, need %h", i, rdata0, le[i]);
            end
            cyc();
            vectors++;
            if (rdata1 !== le[i] || err0 !== 1'b0) begin
                miscompares++;
                $display("FAIL load1_%0d: rdata=%h err=%b, need %h/0", i, rdata1, err0, le[i]);
            end
        end
        idle();
        cyc();
    endtask

    task automatic test_half();
        logic [31:0] la [3] = '{32'h22, 32'h22, 32'h20};
        logic [1:0]  ls [3] = '{SZ_HALF, SZ_HALF, SZ_WORD};
        logic        lx [3] = '{1'b1, 1'b0, 1'b0};
        logic [31:0] le [3] = '{32'hFFFF8001, 32'h00008001, 32'h80010000};
        store(SZ_HALF, 32'h22, 32'h00008001);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, ls[i], lx[i], la[i], 32'h0);
            #1;
            vectors++;
            if (rdata0 !== le[i]) begin
                miscompares++;
                $display("FAIL half0_%0d: rdata=%h, need %h", i, rdata0, le[i]);
            end
            cyc();
            vectors++;
            if (rdata1 !== le[i]) begin
                miscompares++;
                $display("FAIL half1_%0d: rdata=%h, need %h", i, rdata1, le[i]);
            end
        end
        drive(1'b1, 1'b0, SZ_HALF, 1'b1, 32'h21, 32'h0);
        #1;
        vectors++;
        if (rdata0 !== 32'h0) begin
            miscompares++;
            $display("FAIL lh_mis_data0: rdata=%h, need 0", rdata0);
        end
        cyc();
        idle();
        vectors++;
        if (err0 !== 1'b1 || err1 !== 1'b1 || rdata1 !== 32'h0) begin
            miscompares++;
            $display("FAIL lh_mis_err: err=%b/%b rdata1=%h, need 1/1/0", err0, err1, rdata1);
        end
        cyc();
        vectors++;
        if (err0 !== 1'b0) begin
            miscompares++;
            $display("FAIL err_pulse: err=%b, need 0", err0);
        end
        store(SZ_HALF, 32'h21, 32'h00001234);
        vectors++;
        if (err0 !== 1'b1) begin
            miscompares++;
            $display("FAIL sh_mis_err: err=%b, need 1", err0);
        end
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0);
        #1;
        vectors++;
        if (rdata0 !== 32'h80010000) begin
            miscompares++;
            $display("FAIL sh_mis_mem: rdata=%h, need 80010000", rdata0);
        end
        cyc();
        idle();
        cyc();
    endtask

    task automatic test_reject();
        store(SZ_WORD, 32'h400, 32'hFFFFFFFF);
        vectors++;
        if (err0 !== 1'b1) begin
            miscompares++;
            $display("FAIL oor_err: err=%b, need 1", err0);
        end
        store(SZ_WORD, 32'h12, 32'h11111111);
        vectors++;
        if (err0 !== 1'b1) begin
            miscompares++;
            $display("FAIL sw_mis_err: err=%b, need 1", err0);
        end
        store(SZ_WORD, 32'h3FC, 32'hA5A5A5A5);
        vectors++;
        if (err0 !== 1'b0) begin
            miscompares++;
            $display("FAIL last_err: err=%b, need 0", err0);
        end
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
        #1;
        vectors++;
        if (rdata0 !== 32'h0) begin
            miscompares++;
            $display("FAIL oor_word0: rdata=%h, need 0", rdata0);
        end
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
        #1;
        vectors++;
        if (rdata0 !== 32'hDE5ABEEF) begin
            miscompares++;
            $display("FAIL mis_word10: rdata=%h, need DE5ABEEF", rdata0);
        end
        drive(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h3FF, 32'h0);
        #1;
        vectors++;
        if (rdata0 !== 32'h000000A5) begin
            miscompares++;
            $display("FAIL last_byte: rdata=%h, need 000000A5", rdata0);
        end
        drive(1'b1, 1'b0, SZ_RSVD, 1'b0, 32'h10, 32'h0);
        #1;
        vectors++;
        if (rdata0 !== 32'h0) begin
            miscompares++;
            $display("FAIL rsvd_data: rdata=%h, need 0", rdata0);
        end
        cyc();
        idle();
        vectors++;
        if (err0 !== 1'b1 || rdata1 !== 32'h0) begin
            miscompares++;
            $display("FAIL rsvd_err: err=%b rdata1=%h, need 1/0", err0, rdata1);
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        store(SZ_WORD, 32'h30, 32'h1);
        drive(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h30, 32'h2);
        #1;
        vectors++;
        if (rdata0 !== 32'h1) begin
            miscompares++;
            $display("FAIL rw_old0: rdata=%h, need 1", rdata0);
        end
        cyc();
        vectors++;
        if (rdata1 !== 32'h1 || err0 !== 1'b0) begin
            miscompares++;
            $display("FAIL rw_old1: rdata=%h err=%b, need 1/0", rdata1, err0);
        end
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0);
        #1;
        vectors++;
        if (rdata0 !== 32'h2) begin
            miscompares++;
            $display("FAIL rw_new0: rdata=%h, need 2", rdata0);
        end
        cyc();
        idle();
        vectors++;
        if (rdata1 !== 32'h2) begin
            miscompares++;
            $display("FAIL rw_new1: rdata=%h, need 2", rdata1);
        end
        cyc();
        vectors++;
        if (rdata1 !== 32'h0) begin
            miscompares++;
            $display("FAIL rdreg_idle: rdata=%h, need 0", rdata1);
        end
    endtask

    task automatic test_clear_restart();
        int n;
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        repeat (5) cyc();
        store(SZ_WORD, 32'h0, 32'hCAFEF00D);
        vectors++;
        if (err0 !== 1'b1 || busy0 !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_store: err=%b busy=%b, need 1/1", err0, busy0);
        end
        repeat (94) cyc();
        reset = 1'b0;
        repeat (2) cyc();
        vectors++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_busy: busy=%b/%b, need 1/1", busy0, busy1);
        end
        reset = 1'b1;
        count_busy(n);
        vectors++;
        if (n != 256) begin
            miscompares++;
            $display("FAIL restart_length: busy cycles=%0d, need 256", n);
        end
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
        #1;
        vectors++;
        if (rdata0 !== 32'h0) begin
            miscompares++;
            $display("FAIL busy_store_mem: rdata=%h, need 0", rdata0);
        end
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
        #1;
        vectors++;
        if (rdata0 !== 32'h0) begin
            miscompares++;
            $display("FAIL recleared_10: rdata=%h, need 0", rdata0);
        end
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h3FC, 32'h0);
        #1;
        vectors++;
        if (rdata0 !== 32'h0) begin
            miscompares++;
            $display("FAIL recleared_3fc: rdata=%h, need 0", rdata0);
        end
        idle();
        cyc();
    endtask

    initial begin
        test_reset();
        test_byte_word();
        test_half();
        test_reject();
        test_back_to_back();
        test_clear_restart();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
